// File: rtl/boot_load_ctrl.sv
// boot_load_ctrl: boot-time sequencer that streams two flash images from the
// SPI flash reader into the two SPRAM banks (program image to bank 0, data
// image to bank 1), then waits for the hard-IP loader and releases SoC reset.
// Each image ends with an all-ones terminator word. An all-ones word only
// terminates once at least MIN_WORDS words have been written.
module boot_load_ctrl #(
    parameter int unsigned MIN_WORDS       = 1024,
    parameter int unsigned ADDR_W          = 14,
    parameter int unsigned GAP_CYCLES      = 13,
    parameter logic [23:0] SYS0_FLASH_ADDR = 24'h030000,
    parameter logic [23:0] SYS1_FLASH_ADDR = 24'h050000
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              ip_done_i,
    input  logic              fifo_we_i,
    input  logic [31:0]       fifo_data_i,
    output logic              fill_o,
    output logic              fifo_rstn_o,
    output logic [23:0]       flash_addr_o,
    output logic [ADDR_W-1:0] ld_addr_o,
    output logic [31:0]       ld_data_o,
    output logic              ld_we0_o,
    output logic              ld_we1_o,
    output logic              ld_own0_o,
    output logic              ld_own1_o,
    output logic              soc_rstn_o,
    output logic [ADDR_W:0]   words0_o,
    output logic [ADDR_W:0]   words1_o,
    output logic              overflow_o
);

    typedef enum logic [2:0] {
        ST_LOAD0   = 3'd0,
        ST_GAP     = 3'd1,
        ST_LOAD1   = 3'd2,
        ST_WAIT_IP = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Gap counter only has to reach GAP_CYCLES-1; keep it at least one bit.
    localparam int unsigned       GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W:0]   MIN_ADDR  = (ADDR_W + 1)'(MIN_WORDS);
    localparam logic [ADDR_W-1:0] TOP_ADDR  = '1;
    localparam logic [31:0]       TERM_WORD = 32'hFFFF_FFFF;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               fill_q, fill_d;
    logic [ADDR_W:0]    words0_q, words0_d;
    logic [ADDR_W:0]    words1_q, words1_d;
    logic               ovf_q, ovf_d;

    // Write-side qualifiers derived from the current state and the word.
    logic               loading;
    logic               accept;
    logic               word_ones;
    logic               term_hit;
    logic               top_hit;
    logic               seg_end;
    logic               ovf_hit;
    logic [ADDR_W:0]    addr_inc;

    assign loading   = (state_q == ST_LOAD0) || (state_q == ST_LOAD1);
    assign accept    = loading && fifo_we_i;
    assign word_ones = (fifo_data_i == TERM_WORD);
    // All-ones below MIN_WORDS is ordinary image content, not an end marker.
    assign term_hit  = accept && word_ones && ({1'b0, addr_q} >= MIN_ADDR);
    // Last SPRAM word written: the segment must end whatever the word was.
    assign top_hit   = accept && (addr_q == TOP_ADDR);
    assign seg_end   = term_hit || top_hit;
    // A terminator landing on the last word is a clean end, not an overflow.
    assign ovf_hit   = top_hit && !term_hit;
    // Word count including the word being written now.
    assign addr_inc  = {1'b0, addr_q} + (ADDR_W + 1)'(1);

    // State register; reset returns the sequencer to loading bank 0.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_LOAD0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: load bank 0, idle the reader, load bank 1, wait for hard IP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD0: begin
                if (seg_end) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_LOAD1;
                end
            end
            ST_LOAD1: begin
                if (seg_end) begin
                    state_d = ST_WAIT_IP;
                end
            end
            ST_WAIT_IP: begin
                if (ip_done_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Terminal until reset; later ip_done_i activity is ignored.
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_LOAD0;
            end
        endcase
    end

    // Output decode: bank ownership, write strobes, reader control, SoC reset.
    always_comb begin
        ld_we0_o     = 1'b0;
        ld_we1_o     = 1'b0;
        ld_own0_o    = 1'b0;
        ld_own1_o    = 1'b0;
        flash_addr_o = SYS1_FLASH_ADDR;
        fifo_rstn_o  = rstn_i;
        soc_rstn_o   = 1'b0;
        case (state_q)
            ST_LOAD0: begin
                ld_we0_o     = fifo_we_i;
                ld_own0_o    = 1'b1;
                flash_addr_o = SYS0_FLASH_ADDR;
            end
            ST_GAP: begin
                // Hold the reader in reset so it restarts at the bank 1 address.
                fifo_rstn_o = 1'b0;
            end
            ST_LOAD1: begin
                ld_we1_o  = fifo_we_i;
                ld_own1_o = 1'b1;
            end
            ST_DONE: begin
                soc_rstn_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath next-state: word address, gap timer, per-bank counts, overflow flag.
    always_comb begin
        addr_d    = addr_q;
        gap_cnt_d = '0;
        words0_d  = words0_q;
        words1_d  = words1_q;
        ovf_d     = ovf_q;
        fill_d    = loading;
        if (seg_end) begin
            addr_d = '0;
            if (state_q == ST_LOAD0) begin
                words0_d = addr_inc;
            end else begin
                words1_d = addr_inc;
            end
            if (ovf_hit) begin
                ovf_d = 1'b1;
            end
        end else if (accept) begin
            addr_d = addr_q + ADDR_W'(1);
        end else if (!loading) begin
            addr_d = '0;
        end
        if (state_q == ST_GAP) begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
    end

    // Datapath registers; all cleared by reset so a reboot starts from scratch.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            addr_q    <= '0;
            gap_cnt_q <= '0;
            fill_q    <= 1'b0;
            words0_q  <= '0;
            words1_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            gap_cnt_q <= gap_cnt_d;
            fill_q    <= fill_d;
            words0_q  <= words0_d;
            words1_q  <= words1_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ld_addr_o  = addr_q;
    assign ld_data_o  = fifo_data_i;
    assign fill_o     = fill_q;
    assign words0_o   = words0_q;
    assign words1_o   = words1_q;
    assign overflow_o = ovf_q;

endmodule
